// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder sequencer.
// Optional overflow output is enabled by defining CLA_SEQ_OVERFLOW_EN.
package cla_seq_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead adder slice.
// c3 is the carry into bit 3, exposed so the caller can derive signed overflow.
module cla4_slice
   import cla_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co,
   output logic               c3
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum of products of g/p and ci, no ripple chain.
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

   genvar gi;
   generate
      for (gi = 0; gi < SLICE_W; gi++) begin : g_sum
         assign s[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   assign co = c[SLICE_W];
   assign c3 = c[SLICE_W-1];

endmodule

// File: rtl/cla_slice_sequencer.sv
// WIDTH-bit A+B+Cin computed one nibble per cycle, LSB first, on a single shared CLA slice.
// Define CLA_SEQ_OVERFLOW_EN to add the ovf (signed overflow) output.
module cla_slice_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef CLA_SEQ_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = calc_nslice(WIDTH);
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSLICE - 1);

   generate
      if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
         $error("cla_slice_sequencer: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic [WIDTH-1:0]   acc_reg, acc_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               carry_reg, carry_next;
   logic               cout_reg, cout_next;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_co;
   logic               slice_c3;
   logic [WIDTH-1:0]   acc_shift;

   cla4_slice u_slice (
      .a  (a_reg[SLICE_W-1:0]),
      .b  (b_reg[SLICE_W-1:0]),
      .ci (carry_reg),
      .s  (slice_s),
      .co (slice_co),
      .c3 (slice_c3)
   );

   // New nibble enters at the top; after NSLICE steps the first nibble sits at bit 0.
   assign acc_shift = (WIDTH'(slice_s) << (WIDTH - SLICE_W)) | (acc_reg >> SLICE_W);

`ifdef CLA_SEQ_OVERFLOW_EN
   logic ovf_reg, ovf_next;
   assign ovf = ovf_reg;
`else
   logic unused_slice_c3;
   assign unused_slice_c3 = slice_c3;
`endif

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      sum_next   = sum_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_next   = ovf_reg;
`endif
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
               a_next     = a;
               b_next     = b;
               carry_next = cin;
               cnt_next   = '0;
               acc_next   = '0;
            end
         end
         RUN: begin
            busy       = 1'b1;
            acc_next   = acc_shift;
            a_next     = a_reg >> SLICE_W;
            b_next     = b_reg >> SLICE_W;
            carry_next = slice_co;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) begin
               state_next = DONE;
               cnt_next   = '0;
               sum_next   = acc_shift;
               cout_next  = slice_co;
`ifdef CLA_SEQ_OVERFLOW_EN
               ovf_next   = slice_co ^ slice_c3;
`endif
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
         ovf_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
         sum_reg   <= sum_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
`ifdef CLA_SEQ_OVERFLOW_EN
         ovf_reg   <= ovf_next;
`endif
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Scoreboard bench for cla_slice_sequencer: the driver queues hand-computed results, a monitor checks each handoff.
module tb_cla_slice_sequencer;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CLA_SEQ_OVERFLOW_EN
   logic             ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   always #5 clk = ~clk;

   cla_slice_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef CLA_SEQ_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: samples mid-low-phase and pops one expectation per handoff.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum=0x%04h with no expected entry", sum);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               txn++;
               $display("txn %0d: sum=0x%04h cout=%0b (expected sum=0x%04h cout=%0b)",
                        txn, sum, cout, e.sum, e.cout);
               chk("result_sum", sum, e.sum);
               chk("result_cout", cout, e.cout);
`ifdef CLA_SEQ_OVERFLOW_EN
               chk("result_ovf", ovf, e.ovf);
`endif
            end
         end
      end
   end

   task automatic run_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                          input bit noisy, input int hold);
      exp_t e;
      int   wait_cnt;
      @(negedge clk);
      a         = va;
      b         = vb;
      cin       = vc;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      chk("accept_ready", in_ready, 1);
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      exp_q.push_back(e);
      @(negedge clk);
      if (noisy) begin
         a   = '1;
         b   = '1;
         cin = 1'b1;
      end else begin
         in_valid = 1'b0;
      end
      chk("busy_in_run", busy, 1);
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 20) begin
         if (noisy) chk("no_accept_in_run", in_ready, 0);
         @(negedge clk);
         wait_cnt++;
      end
      chk("latency", wait_cnt, NSLICE);
      in_valid = 1'b0;
      if (!out_valid) begin
         void'(exp_q.pop_back());
         return;
      end
      for (int i = 0; i < hold; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_sum_held", sum, es);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("handoff_in_ready", in_ready, 1);
      chk("handoff_out_valid", out_valid, 0);
      chk("handoff_busy", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", cout, 0);
      rst = 1'b0;

      //        a         b         cin   sum       cout  ovf  noisy hold
      run_vec(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
      run_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
      run_vec(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
      run_vec(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 0);
      run_vec(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 3);

      // Reset while the slice is at step 2 of a 0x1111+0x2222 add.
      @(negedge clk);
      a         = 16'h1111;
      b         = 16'h2222;
      cin       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk("abort_accept_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_abort_in_ready", in_ready, 1);
      chk("after_abort_out_valid", out_valid, 0);

      run_vec(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 0);
      run_vec(16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0, 1'b0, 0);
      run_vec(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0);
      run_vec(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
      run_vec(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("results_seen", txn, 10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Multi-cycle adder controller that computes WIDTH-bit A+B+Cin by time-sharing one 4-bit carry-lookahead slice. It processes one nibble per cycle, LSB first, and carries between cycles through a registered carry. It sits between a requester and a consumer, with valid/ready handshakes on both sides. It trades latency for area wherever a full-width adder is too large.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived localparam; number of nibble steps per operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- State machine states:
  - IDLE: in_ready=1.
  - RUN: slice stepping.
  - DONE: out_valid=1.
- State transitions:
  - IDLE -> RUN on in_valid&&in_ready.
    - Captures a, b and cin into registers.
    - Step counter cleared to 0.
    - Sum shift register cleared.
  - RUN, each cycle:
    - Slice sees the low nibble of the A/B shift registers plus the carry register.
    - Slice sum shifts into the top of the sum register.
    - A/B registers shift right by 4.
    - Carry register takes the slice carry-out.
    - Counter increments.
  - RUN -> DONE on the edge that processes step NSLICE-1.
    - Latency: out_valid rises exactly NSLICE cycles after the accepting edge (4 cycles at WIDTH=16).
  - DONE: sum and cout are held stable while out_valid=1 && out_ready=0.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE) only.
  - No accept in the same cycle as result handoff.
  - Back-to-back throughput is one result per NSLICE+2 cycles with out_ready held high.
- While not in IDLE, inputs a, b, cin and in_valid are ignored. A captured operand is never disturbed.
- out_ready in IDLE/RUN is ignored.
- sum and cout:
  - Update only on the RUN->DONE edge.
  - Hold their last value in IDLE and RUN.
  - Are not qualified by anything except out_valid.
- Arithmetic is unsigned modulo 2^WIDTH. cout = bit WIDTH of A+B+Cin.
- Reset values, async on rst:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Counter=0, carry register=0, operand registers=0.
- Reset mid-RUN or mid-DONE aborts the operation. No partial result is emitted. in_ready=1 in the first cycle after rst deasserts.
- WIDTH=4: a single RUN step; DONE one cycle after accept.

Optional Feature:
- Macro: CLA_SEQ_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow of the WIDTH-bit add.
  - ovf = carry into MSB XOR carry out of MSB, captured from the final slice step.
  - ovf updates only on the RUN->DONE edge and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package cla_seq_pkg:
  - State enum: IDLE, RUN, DONE.
  - SLICE_W=4 constant.
  - Function computing NSLICE from WIDTH.
- One sub-module: cla4_slice.
  - Combinational 4-bit generate/propagate lookahead slice.
  - Inputs: a[3:0], b[3:0], ci. Outputs: s[3:0], co, c3 (carry into bit 3, needed for ovf).
  - Instantiated once.

Test Plan:
- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid high 4 cycles after accept; sum=0x5555, cout=0; in_ready back to 1 one cycle later.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Backpressure: a=0x00F0, b=0x0010, out_ready low for 3 cycles after out_valid → sum=0x0100 held stable, out_valid stays 1, in_ready stays 0. Completes on the out_ready edge.
- Input-change immunity: accept a=0x8000, b=0x8000, then drive a=0xFFFF and in_valid=1 during RUN → result sum=0x0000, cout=1; no second accept until IDLE.
- Reset mid-RUN: assert rst at step 2 → out_valid=0, sum=0 immediately; in_ready=1 after release. The next request a=0x0003, b=0x0004 yields sum=0x0007.
- Overflow (CLA_SEQ_OVERFLOW_EN): a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0. a=0xFFFF, b=0x0001 → ovf=0, cout=1.
